mac_perceptron: RTL

- Parametrised, time-multiplexed successor to the fully parallel perceptron.
- One signed multiply-accumulate per accepted beat, streamed over valid/ready.
- Adds bias, applies ReLU, saturates to the output width and presents the result on a valid/ready output.
- Sits between the feature/weight stream sources and the next MLP layer; one instance per neuron.

---
 rtl/mac_perceptron.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mac_perceptron.sv
// mac_perceptron: streamed signed MAC neuron (bias, ReLU, saturation) over valid/ready.
// Optional build macro MAC_PERCEPTRON_LEAKY_RELU_EN selects leaky ReLU (slope 1/8).
`default_nettype none

module mac_perceptron #(
  parameter int N_INPUTS = 50,
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 16,
  parameter int ACC_W    = 40,
  parameter int OUT_W    = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [ACC_W-1:0] bias,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [COEF_W-1:0]       in_coef,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_data,
  output logic                    out_sat,
  output logic                    out_short
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int CNT_W  = $clog2(N_INPUTS + 1);

  localparam logic signed [ACC_W-1:0] MAX_POS = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
`ifdef MAC_PERCEPTRON_LEAKY_RELU_EN
  localparam logic signed [ACC_W-1:0] MIN_NEG = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  state_t                  state, state_nx;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        cnt;
  logic                    ready_en;

  logic [PROD_W-1:0]       product;
  logic signed [ACC_W-1:0] product_ext;
  logic signed [ACC_W-1:0] sum;
  logic [CNT_W-1:0]        cnt_inc;
  logic                    beat;
  logic                    frame_end;
  logic [OUT_W-1:0]        act_data;
  logic                    act_sat;
`ifdef MAC_PERCEPTRON_LEAKY_RELU_EN
  logic signed [ACC_W-1:0] leaky;
`endif

  // Operands are sign-extended to the full product width so an unsigned
  // multiply yields the exact signed product in the low PROD_W bits.
  assign product     = {{COEF_W{in_data[DATA_W-1]}}, in_data} *
                       {{DATA_W{in_coef[COEF_W-1]}}, in_coef};
  assign product_ext = {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};

  assign in_ready  = ready_en && (state != OUTPUT);
  assign out_valid = (state == OUTPUT);
  assign beat      = in_valid && in_ready;
  assign cnt_inc   = cnt + CNT_W'(1);
  assign frame_end = in_last || (cnt_inc == CNT_W'(N_INPUTS));
  // cnt is zero in IDLE, so the first beat seeds from bias with the same adder.
  assign sum       = ((state == IDLE) ? bias : acc) + product_ext;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, ACCUM: if (beat) state_nx = frame_end ? OUTPUT : ACCUM;
      OUTPUT:      if (out_ready) state_nx = IDLE;
      default:     state_nx = IDLE;
    endcase
  end

  always_comb begin
    act_data = '0;
    act_sat  = 1'b0;
`ifdef MAC_PERCEPTRON_LEAKY_RELU_EN
    leaky    = sum >>> 3;
`endif
    if (sum > MAX_POS) begin
      act_data = MAX_POS[OUT_W-1:0];
      act_sat  = 1'b1;
    end else if (!sum[ACC_W-1] && (sum != '0)) begin
      act_data = sum[OUT_W-1:0];
    end else begin
`ifdef MAC_PERCEPTRON_LEAKY_RELU_EN
      if (leaky < MIN_NEG) begin
        act_data = MIN_NEG[OUT_W-1:0];
        act_sat  = 1'b1;
      end else begin
        act_data = leaky[OUT_W-1:0];
      end
`else
      act_data = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en  <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      out_short <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (beat) begin
        acc <= sum;
        cnt <= cnt_inc;
        if (frame_end) begin
          out_data  <= act_data;
          out_sat   <= act_sat;
          out_short <= (cnt_inc != CNT_W'(N_INPUTS));
        end
      end
      if ((state == OUTPUT) && out_ready) cnt <= '0;
    end
  end

endmodule

`default_nettype wire
